// File: rtl/tape_rec.sv
// tape_rec: cassette recorder, decodes pulse-width cass bits into bytes and writes them to the tape area
// Ports:
//   clk, reset            100 MHz clock, asynchronous active-high reset
//   ctrl[1:0]             tape control (10 = REC, anything else stops recording)
//   cass                  CPU cassette output, asynchronous to clk
//   mem_addr/data/req/ack byte write port; req held until a one-cycle ack
//   length                bytes committed since REC entry
//   recording             registered ctrl==REC
//   overrun, full         sticky status, cleared on REC entry
module tape_rec #(
  parameter int THRESH = 40000,
  parameter int MIN_PERIOD = 5000,
  parameter int TIMEOUT = 200000,
  parameter int CNT_W = 18
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  ctrl,
  input  logic        cass,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [15:0] length,
  output logic        recording,
  output logic        overrun,
  output logic        full
);
  typedef enum logic [2:0] {IDLE, HUNT, DATA, STOP1, STOP2} state_t;
  localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] CNT_TH = CNT_W'(THRESH);
  state_t state, state_nx;
  logic sync1, sync2, sync3;
  logic [CNT_W-1:0] cnt;
  logic bit_v, bit_val;
  logic [7:0] sh, sh_nx;
  logic [2:0] bitcnt, bitcnt_nx;
  logic commit, commit_nx;
  logic rec, entry, rise, timeout, edge_ok;
  assign rec = ctrl == 2'b10;
  // IDLE is only ever seen with rec high on the first REC cycle
  assign entry = rec && state == IDLE;
  assign rise = sync2 && !sync3;
  assign timeout = cnt == CNT_TO;
  // Edges too close to the previous one are glitches and leave the counter running
  assign edge_ok = rise && cnt >= CNT_MIN;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {sync1, sync2, sync3} <= 3'b000;
      cnt <= '0;
      bit_v <= 1'b0;
      bit_val <= 1'b0;
    end else begin
      {sync1, sync2, sync3} <= {cass, sync1, sync2};
      cnt <= entry ? CNT_TO : edge_ok ? '0 : timeout ? cnt : cnt + CNT_W'(1);
      // An edge after a saturated count only resynchronises, it carries no bit
      bit_v <= edge_ok && !timeout && !entry;
      bit_val <= cnt < CNT_TH;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sh <= 8'h00;
      bitcnt <= 3'd0;
      commit <= 1'b0;
    end else begin
      state <= state_nx;
      sh <= sh_nx;
      bitcnt <= bitcnt_nx;
      commit <= commit_nx;
    end
  end
  always_comb begin
    state_nx = state;
    sh_nx = sh;
    bitcnt_nx = bitcnt;
    commit_nx = 1'b0;
    if (!rec) state_nx = IDLE;
    else if (state == IDLE) state_nx = HUNT;
    else if (timeout && state != HUNT) state_nx = HUNT;
    else if (bit_v)
      case (state)
        HUNT: begin
          state_nx = bit_val ? HUNT : DATA;
          bitcnt_nx = 3'd0;
        end
        DATA: begin
          sh_nx = {bit_val, sh[7:1]};
          bitcnt_nx = bitcnt + 3'd1;
          state_nx = bitcnt == 3'd7 ? STOP1 : DATA;
        end
        STOP1: state_nx = bit_val ? STOP2 : HUNT;
        STOP2: begin
          state_nx = HUNT;
          commit_nx = bit_val;
        end
        default: state_nx = IDLE;
      endcase
  end
  // sh is stable in HUNT, so the byte is still valid the cycle after commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr <= 16'h0000;
      mem_data <= 8'h00;
      mem_req <= 1'b0;
      length <= 16'h0000;
      recording <= 1'b0;
      overrun <= 1'b0;
      full <= 1'b0;
    end else begin
      recording <= rec;
      if (mem_req && mem_ack) begin
        mem_req <= 1'b0;
        if (length == 16'hFFFF) full <= 1'b1;
        else length <= length + 16'd1;
      end
      if (commit && mem_req) overrun <= 1'b1;
      else if (commit && !full) begin
        mem_req <= 1'b1;
        mem_addr <= length;
        mem_data <= sh;
      end
      if (entry) begin
        length <= 16'h0000;
        overrun <= 1'b0;
        full <= 1'b0;
      end
    end
  end
endmodule
